// File: rtl/contador_ocupacion.sv
`default_nettype none
// ============================================================================
// Module   : contador_ocupacion
// Brief    : Occupancy counter driven by entry/exit level sensors, counting
//            each rising edge once. Optional macro CONTADOR_OCUPACION_SYNC_EN
//            adds two-flop sensor synchronizers (latency 1 -> 3 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module contador_ocupacion #(
    parameter int WIDTH     = 4,
    parameter int CAPACIDAD = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             z1,
    input  logic             z2,
    output logic [WIDTH-1:0] c,
    output logic             lleno,
    output logic             vacio,
    output logic [WIDTH-1:0] libres,
    output logic             err_lleno,
    output logic             err_vacio
);

    localparam logic [WIDTH-1:0] c_CAP  = WIDTH'(CAPACIDAD);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic             w_z1_s;
    logic             w_z2_s;
    logic             w_ent;
    logic             w_sal;
    logic             z1_q;
    logic             z2_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] c_d;
    logic             err_lleno_q;
    logic             err_lleno_d;
    logic             err_vacio_q;
    logic             err_vacio_d;

`ifdef CONTADOR_OCUPACION_SYNC_EN
    logic [1:0] z1_sync_q;
    logic [1:0] z2_sync_q;

    // Synchronizers reset high so a sensor already active at release is not seen as a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            z1_sync_q <= 2'b11;
            z2_sync_q <= 2'b11;
        end else begin
            z1_sync_q <= {z1_sync_q[0], z1};
            z2_sync_q <= {z2_sync_q[0], z2};
        end
    end

    assign w_z1_s = z1_sync_q[1];
    assign w_z2_s = z2_sync_q[1];
`else
    assign w_z1_s = z1;
    assign w_z2_s = z2;
`endif

    assign w_ent = w_z1_s & ~z1_q;
    assign w_sal = w_z2_s & ~z2_q;

    always_comb begin
        c_d         = c_q;
        err_lleno_d = 1'b0;
        err_vacio_d = 1'b0;
        if (en) begin
            if (w_ent && !w_sal) begin
                if (c_q == c_CAP) begin
                    err_lleno_d = 1'b1;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end else if (w_sal && !w_ent) begin
                if (c_q == c_ZERO) begin
                    err_vacio_d = 1'b1;
                end else begin
                    c_d = c_q - 1'b1;
                end
            end
        end
    end

    // Previous-sample registers keep tracking even while disabled, so edges during en=0 are lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            z1_q        <= 1'b1;
            z2_q        <= 1'b1;
            c_q         <= '0;
            err_lleno_q <= 1'b0;
            err_vacio_q <= 1'b0;
        end else begin
            z1_q        <= w_z1_s;
            z2_q        <= w_z2_s;
            c_q         <= c_d;
            err_lleno_q <= err_lleno_d;
            err_vacio_q <= err_vacio_d;
        end
    end

    assign c         = c_q;
    assign lleno     = (c_q == c_CAP);
    assign vacio     = (c_q == c_ZERO);
    assign libres    = c_CAP - c_q;
    assign err_lleno = err_lleno_q;
    assign err_vacio = err_vacio_q;

endmodule
`default_nettype wire

// File: tb/tb_contador_ocupacion.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_ocupacion
// Brief    : Table-driven self-checking bench for contador_ocupacion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_ocupacion;

    localparam int WIDTH = 4;
    localparam int CAP   = 12;

    logic             clk;
    logic             reset;
    logic             en;
    logic             z1;
    logic             z2;
    logic [WIDTH-1:0] c;
    logic             lleno;
    logic             vacio;
    logic [WIDTH-1:0] libres;
    logic             err_lleno;
    logic             err_vacio;

    typedef struct {
        logic             rst;
        logic             en;
        logic             z1;
        logic             z2;
        logic [WIDTH-1:0] c;
        logic             el;
        logic             ev;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    contador_ocupacion #(
        .WIDTH     (WIDTH),
        .CAPACIDAD (CAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .z1        (z1),
        .z2        (z2),
        .c         (c),
        .lleno     (lleno),
        .vacio     (vacio),
        .libres    (libres),
        .err_lleno (err_lleno),
        .err_vacio (err_vacio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic a, input logic b,
                       input int ec, input logic el, input logic ev);
        vec_t v;
        v.rst = r; v.en = e; v.z1 = a; v.z2 = b;
        v.c = WIDTH'(ec); v.el = el; v.ev = ev;
        tbl.push_back(v);
    endtask

    task automatic check_row(input int idx);
        vec_t             e;
        logic             x_lleno;
        logic             x_vacio;
        logic [WIDTH-1:0] x_libres;
        e        = sb.pop_front();
        x_lleno  = (e.c == WIDTH'(CAP));
        x_vacio  = (e.c == '0);
        x_libres = WIDTH'(CAP) - e.c;
        checks++;
        if ({c, lleno, vacio, libres, err_lleno, err_vacio} !==
            {e.c, x_lleno, x_vacio, x_libres, e.el, e.ev}) begin
            failures++;
            $display("FAIL row%0d: got c=%0d lleno=%0b vacio=%0b libres=%0d el=%0b ev=%0b, required c=%0d lleno=%0b vacio=%0b libres=%0d el=%0b ev=%0b",
                     idx, c, lleno, vacio, libres, err_lleno, err_vacio,
                     e.c, x_lleno, x_vacio, x_libres, e.el, e.ev);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; z1 = 1'b0; z2 = 1'b0;

`ifdef CONTADOR_OCUPACION_SYNC_EN
        add(1,1,0,0, 0,0,0); add(1,1,0,0, 0,0,0);
        for (int k = 0; k < 4; k++) add(0,1,0,0, 0,0,0);
        // z1 rise reaches c on the third edge
        add(0,1,1,0, 0,0,0); add(0,1,1,0, 0,0,0); add(0,1,1,0, 1,0,0);
        add(0,1,1,0, 1,0,0);
        for (int k = 0; k < 3; k++) add(0,1,0,0, 1,0,0);
        // pulse while disabled is lost
        for (int k = 0; k < 3; k++) add(0,0,1,0, 1,0,0);
        for (int k = 0; k < 3; k++) add(0,0,0,0, 1,0,0);
        for (int k = 0; k < 3; k++) add(0,1,0,0, 1,0,0);
        add(0,1,0,1, 1,0,0); add(0,1,0,1, 1,0,0); add(0,1,0,1, 0,0,0);
        for (int k = 0; k < 3; k++) add(0,1,0,0, 0,0,0);
        add(0,1,0,1, 0,0,0); add(0,1,0,1, 0,0,0); add(0,1,0,1, 0,0,1);
        add(0,1,0,1, 0,0,0);
        for (int k = 0; k < 3; k++) add(0,1,0,0, 0,0,0);
`else
        add(1,1,0,0, 0,0,0); add(1,1,0,0, 0,0,0);
        add(0,1,0,0, 0,0,0);
        // three 4-cycle pulses, one count each
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) add(0,1,1,0, p+1,0,0);
            for (int k = 0; k < 2; k++) add(0,1,0,0, p+1,0,0);
        end
        for (int p = 3; p < 12; p++) begin
            add(0,1,1,0, p+1,0,0); add(0,1,0,0, p+1,0,0);
        end
        // entry at full: single error pulse even with the sensor held
        add(0,1,1,0, 12,1,0); add(0,1,1,0, 12,0,0); add(0,1,1,0, 12,0,0);
        add(0,1,0,0, 12,0,0);
        add(0,1,1,1, 12,0,0); add(0,1,0,0, 12,0,0);
        for (int p = 11; p >= 5; p--) begin
            add(0,1,0,1, p,0,0); add(0,1,0,0, p,0,0);
        end
        add(0,1,1,1, 5,0,0); add(0,1,0,0, 5,0,0);
        add(0,0,1,0, 5,0,0); add(0,0,1,0, 5,0,0);
        add(0,1,1,0, 5,0,0); add(0,1,0,0, 5,0,0);
        for (int p = 4; p >= 0; p--) begin
            add(0,1,0,1, p,0,0); add(0,1,0,0, p,0,0);
        end
        add(0,1,0,1, 0,0,1); add(0,1,0,0, 0,0,0);
        add(0,1,1,1, 0,0,0); add(0,1,0,0, 0,0,0);
        // sensor high across reset release
        add(1,1,1,0, 0,0,0); add(1,1,1,0, 0,0,0);
        for (int k = 0; k < 10; k++) add(0,1,1,0, 0,0,0);
        add(0,1,0,0, 0,0,0); add(0,1,1,0, 1,0,0); add(0,1,0,0, 1,0,0);
        // reset wins over a same-cycle edge
        add(1,1,1,0, 0,0,0); add(0,1,1,0, 0,0,0); add(0,1,0,0, 0,0,0);
        add(0,1,1,0, 1,0,0); add(0,1,0,0, 1,0,0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; en = tbl[i].en; z1 = tbl[i].z1; z2 = tbl[i].z2;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            check_row(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/contador_ocupacion.md
CONTADOR_OCUPACION -- requirements
Module: contador_ocupacion

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the bit width of the occupancy count.
REQ-002 The module SHALL have parameter CAPACIDAD, default 12, giving the maximum occupancy; legal only if 1 <= CAPACIDAD <= 2^WIDTH-1.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, the reset; it is synchronous and active-high.
REQ-005 The module SHALL have port en, input, 1 bit, the count enable; when 0, sensor edges are ignored.
REQ-006 The module SHALL have port z1, input, 1 bit, the entry sensor, level-active.
REQ-007 The module SHALL have port z2, input, 1 bit, the exit sensor, level-active.
REQ-008 The module SHALL have port c, output, WIDTH bits, the current occupancy (registered).
REQ-009 The module SHALL have port lleno, output, 1 bit, asserted when c == CAPACIDAD.
REQ-010 The module SHALL have port vacio, output, 1 bit, asserted when c == 0.
REQ-011 The module SHALL have port libres, output, WIDTH bits, equal to CAPACIDAD - c.
REQ-012 The module SHALL have port err_lleno, output, 1 bit, a one-cycle pulse for an entry rejected at full.
REQ-013 The module SHALL have port err_vacio, output, 1 bit, a one-cycle pulse for an exit rejected at empty.

Function
REQ-014 The module SHALL keep one previous-sample register per sensor (z1_q, z2_q); entry edge = z1 & ~z1_q, exit edge = z2 & ~z2_q.
REQ-015 The module SHALL count each sensor assertion exactly once, however many cycles the sensor stays high.
REQ-016 On an entry edge alone with en=1 and c < CAPACIDAD, the module SHALL increment c at that same clock edge, giving 1-cycle latency from input to output.
REQ-017 On an exit edge alone with en=1 and c > 0, the module SHALL decrement c at that same clock edge.
REQ-018 On simultaneous entry and exit edges with en=1, the module SHALL leave c unchanged and assert no error, including when c is 0 or at CAPACIDAD.
REQ-019 On an entry edge alone with en=1 and c == CAPACIDAD, the module SHALL hold c and assert err_lleno for exactly one cycle.
REQ-020 On an exit edge alone with en=1 and c == 0, the module SHALL hold c and assert err_vacio for exactly one cycle.
REQ-021 The module SHALL ensure c never exceeds CAPACIDAD and never wraps below 0.
REQ-022 With en=0, the module SHALL hold c, keep errors at 0, and keep updating z1_q/z2_q every cycle, so an edge occurring while disabled is lost.
REQ-023 The module SHALL register lleno, vacio and libres, or derive them combinationally from the registered c, so they are always consistent with c in the same cycle.
REQ-024 err_lleno and err_vacio SHALL be registered and asserted in the cycle after the edge that caused them.

Reset
REQ-025 While reset=1 at a rising clk edge, the module SHALL set c=0, vacio=1, lleno=0, libres=CAPACIDAD, err_lleno=0 and err_vacio=0.
REQ-026 Reset SHALL set z1_q=1 and z2_q=1, so a sensor held high across reset release produces no count until it falls and rises again.
REQ-027 Reset asserted mid-operation SHALL take priority over any edge in the same cycle.

Configuration
REQ-028 With macro CONTADOR_OCUPACION_SYNC_EN defined, the module SHALL pass z1 and z2 through two-flop synchronizers (reset to 1) before edge detection, raising input-to-c latency to 3 cycles.
REQ-029 Without CONTADOR_OCUPACION_SYNC_EN, the module SHALL sample the sensors directly, with 1-cycle latency, and all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: reset, then 3 z1 pulses each 4 cycles long -> c=3, libres=9, vacio=0, lleno=0, one increment per pulse.
REQ-031 Scenario: 12 z1 pulses, then one more -> c=12, lleno=1, err_lleno pulses once, and c stays at 12.
REQ-032 Scenario: from reset, one z2 pulse -> err_vacio pulses once, c=0, vacio=1.
REQ-033 Scenario: c=5, z1 and z2 rising in the same cycle -> c=5, no error pulse.
REQ-034 Scenario: z1 held high through reset release for 10 cycles -> c=0; z1 falls and rises again -> c=1.
REQ-035 Scenario: with en=0, a z1 pulse arrives, then en=1 -> c unchanged; repeat the run with CONTADOR_OCUPACION_SYNC_EN defined and check that c updates 3 cycles after a z1 rise.
